// File: rtl/type_definitions_pkg.sv
// Shared RV32IM types: mnemonic enum, raw instruction formats, decoder output record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package type_definitions_pkg;

    typedef enum logic [5:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
        MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU,
        ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
        LB, LH, LW, LBU, LHU,
        SB, SH, SW,
        BEQ, BNE, BLT, BGE, BLTU, BGEU,
        LUI, AUIPC, JAL, JALR
    } instructions;

    localparam int NUM_INSTR = 45;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } r_type_t;

    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_type_t;

    typedef struct packed {
        logic [6:0] imm_11to5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_4to0;
        logic [6:0] opcode;
    } s_type_t;

    typedef struct packed {
        logic       imm_12;
        logic [5:0] imm_10to5;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [3:0] imm_4to1;
        logic       imm_11;
        logic [6:0] opcode;
    } sb_type_t;

    typedef struct packed {
        logic [19:0] imm_31to12;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } u_type_t;

    typedef struct packed {
        logic       imm_20;
        logic [9:0] imm_10to1;
        logic       imm_11;
        logic [7:0] imm_19to12;
        logic [4:0] rd;
        logic [6:0] opcode;
    } uj_type_t;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FMT_R  = 3'd0,
        FMT_I  = 3'd1,
        FMT_S  = 3'd2,
        FMT_SB = 3'd3,
        FMT_U  = 3'd4,
        FMT_UJ = 3'd5
    } instr_fmt_e;

    typedef struct packed {
        instructions op;
        instr_fmt_e  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } decoded_instr_t;

endpackage

// File: rtl/rv_instr_decode_comb.sv
// Pure decode of one RV32IM word into a decoded_instr_t record.
// Latency: 0 cycles (combinational).
// Backpressure: none; the caller decides when to capture the result.
module rv_instr_decode_comb
    import type_definitions_pkg::*;
(
    input  logic [31:0]    instr,
    output decoded_instr_t dec
);

    r_type_t     f;
    instructions op;
    instr_fmt_e  fmt;
    logic        legal;
    logic [31:0] imm_i, imm_sh, imm_s, imm_sb, imm_u, imm_uj;

    assign f      = r_type_t'(instr);
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_sh = {27'b0, instr[24:20]};
    assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_sb = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u  = {instr[31:12], 12'b0};
    assign imm_uj = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Classify opcode/funct3/funct7 into a mnemonic, its format and legality
    always_comb begin
        op    = ADD;
        fmt   = FMT_R;
        legal = 1'b1;
        case (f.opcode)
            OPC_R: begin
                fmt = FMT_R;
                case (f.funct7)
                    7'b0000000: begin
                        case (f.funct3)
                            3'b000: op = ADD;
                            3'b001: op = SLL;
                            3'b010: op = SLT;
                            3'b011: op = SLTU;
                            3'b100: op = XOR;
                            3'b101: op = SRL;
                            3'b110: op = OR;
                            default: op = AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (f.funct3 == 3'b000)      op = SUB;
                        else if (f.funct3 == 3'b101) op = SRA;
                        else                         legal = 1'b0;
                    end
                    7'b0000001: begin
                        case (f.funct3)
                            3'b000: op = MUL;
                            3'b001: op = MULH;
                            3'b010: op = MULHSU;
                            3'b011: op = MULHU;
                            3'b100: op = DIV;
                            3'b101: op = DIVU;
                            3'b110: op = REM;
                            default: op = REMU;
                        endcase
                    end
                    default: legal = 1'b0;
                endcase
            end
            OPC_I: begin
                fmt = FMT_I;
                case (f.funct3)
                    3'b000: op = ADDI;
                    3'b010: op = SLTI;
                    3'b011: op = SLTIU;
                    3'b100: op = XORI;
                    3'b110: op = ORI;
                    3'b111: op = ANDI;
                    3'b001: begin
                        if (f.funct7 == 7'b0000000) op = SLLI;
                        else                        legal = 1'b0;
                    end
                    default: begin
                        if (f.funct7 == 7'b0000000)      op = SRLI;
                        else if (f.funct7 == 7'b0100000) op = SRAI;
                        else                             legal = 1'b0;
                    end
                endcase
            end
            OPC_LOAD: begin
                fmt = FMT_I;
                case (f.funct3)
                    3'b000: op = LB;
                    3'b001: op = LH;
                    3'b010: op = LW;
                    3'b100: op = LBU;
                    3'b101: op = LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                fmt = FMT_S;
                case (f.funct3)
                    3'b000: op = SB;
                    3'b001: op = SH;
                    3'b010: op = SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                fmt = FMT_SB;
                case (f.funct3)
                    3'b000: op = BEQ;
                    3'b001: op = BNE;
                    3'b100: op = BLT;
                    3'b101: op = BGE;
                    3'b110: op = BLTU;
                    3'b111: op = BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI:   begin fmt = FMT_U;  op = LUI;   end
            OPC_AUIPC: begin fmt = FMT_U;  op = AUIPC; end
            OPC_JAL:   begin fmt = FMT_UJ; op = JAL;   end
            OPC_JALR: begin
                fmt = FMT_I;
                op  = JALR;
                if (f.funct3 != 3'b000) legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
    end

    // Populate only the fields the format carries; illegal words collapse to ADD with zeros
    always_comb begin
        dec = '0;
        if (legal) begin
            dec.op  = op;
            dec.fmt = fmt;
            case (fmt)
                FMT_R: begin
                    dec.rd  = f.rd;
                    dec.rs1 = f.rs1;
                    dec.rs2 = f.rs2;
                end
                FMT_I: begin
                    dec.rd  = f.rd;
                    dec.rs1 = f.rs1;
                    dec.imm = (op == SLLI || op == SRLI || op == SRAI) ? imm_sh : imm_i;
                end
                FMT_S: begin
                    dec.rs1 = f.rs1;
                    dec.rs2 = f.rs2;
                    dec.imm = imm_s;
                end
                FMT_SB: begin
                    dec.rs1 = f.rs1;
                    dec.rs2 = f.rs2;
                    dec.imm = imm_sb;
                end
                FMT_U: begin
                    dec.rd  = f.rd;
                    dec.imm = imm_u;
                end
                FMT_UJ: begin
                    dec.rd  = f.rd;
                    dec.imm = imm_uj;
                end
                default: ;
            endcase
        end else begin
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/rv_instr_decoder.sv
// RV32IM stream decoder with 2-entry output skid buffer and saturating per-mnemonic counters.
// Latency: 1 cycle from input accept to out_valid (no same-cycle bypass).
// Backpressure: in_ready drops while both buffer entries are occupied; head holds until out_ready.
module rv_instr_decoder
    import type_definitions_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       out_op,
    output logic [2:0]       out_fmt,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [31:0]      out_imm,
    output logic             out_illegal,
    input  logic [5:0]       stat_sel,
    output logic [CNT_W-1:0] stat_count,
    output logic [CNT_W-1:0] illegal_count,
    input  logic             stat_clear
);

    typedef enum logic [1:0] {BUF_EMPTY, BUF_ONE, BUF_TWO} buf_state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    buf_state_e       state, state_nxt;
    decoded_instr_t   dec, head, tail;
    logic             push, pop;
    logic [CNT_W-1:0] cnt_q [NUM_INSTR];
    logic [CNT_W-1:0] ill_q;

    rv_instr_decode_comb u_decode (
        .instr (in_instr),
        .dec   (dec)
    );

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Buffer occupancy register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BUF_EMPTY;
        else     state <= state_nxt;
    end

    // Occupancy update: a simultaneous push and pop leaves the count unchanged
    always_comb begin
        state_nxt = state;
        case (state)
            BUF_EMPTY: if (push) state_nxt = BUF_ONE;
            BUF_ONE: begin
                if (push && !pop)      state_nxt = BUF_TWO;
                else if (!push && pop) state_nxt = BUF_EMPTY;
            end
            BUF_TWO: if (pop) state_nxt = BUF_ONE;
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    // Handshake outputs depend only on occupancy
    always_comb begin
        in_ready  = (state != BUF_TWO);
        out_valid = (state != BUF_EMPTY);
    end

    // Entry storage: head is always presented, tail only fills while head is stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            case (state)
                BUF_EMPTY: if (push) head <= dec;
                BUF_ONE: begin
                    if (push && pop) head <= dec;
                    else if (push)   tail <= dec;
                end
                BUF_TWO: if (pop) head <= tail;
                default: ;
            endcase
        end
    end

    // Saturating statistics, counted at accept time; clear beats increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_INSTR; i++) cnt_q[i] <= '0;
            ill_q <= '0;
        end else if (stat_clear) begin
            for (int i = 0; i < NUM_INSTR; i++) cnt_q[i] <= '0;
            ill_q <= '0;
        end else if (push) begin
            if (dec.illegal) begin
                if (ill_q != CNT_MAX) ill_q <= ill_q + 1'b1;
            end else if (cnt_q[dec.op] != CNT_MAX) begin
                cnt_q[dec.op] <= cnt_q[dec.op] + 1'b1;
            end
        end
    end

    assign stat_count    = (stat_sel < 6'(NUM_INSTR)) ? cnt_q[stat_sel] : '0;
    assign illegal_count = ill_q;

    assign out_op      = head.op;
    assign out_fmt     = head.fmt;
    assign out_rd      = head.rd;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;

endmodule

// File: tb/tb_rv_instr_decoder.sv
`timescale 1ns/1ps
module tb_rv_instr_decoder;
    import type_definitions_pkg::*;

    localparam int CNT_W   = 16;
    localparam int SAT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid, in_ready, out_valid, out_ready, out_illegal, stat_clear;
    logic [31:0]      in_instr, out_imm;
    logic [5:0]       out_op, stat_sel;
    logic [2:0]       out_fmt;
    logic [4:0]       out_rd, out_rs1, out_rs2;
    logic [CNT_W-1:0] stat_count, illegal_count;

    always #5 clk = ~clk;

    rv_instr_decoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op(out_op), .out_fmt(out_fmt), .out_rd(out_rd), .out_rs1(out_rs1),
        .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal),
        .stat_sel(stat_sel), .stat_count(stat_count),
        .illegal_count(illegal_count), .stat_clear(stat_clear)
    );

    typedef struct packed {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        instr_fmt_e fmt;
    } enc_t;

    int             n_tests = 0;
    int             n_fail  = 0;
    decoded_instr_t exp_q[$];
    decoded_instr_t pend;
    int             model_cnt[NUM_INSTR];
    int             model_ill;
    bit             acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic decoded_instr_t mk(instructions op, instr_fmt_e fmt, logic [4:0] rd,
                                          logic [4:0] rs1, logic [4:0] rs2, logic [31:0] imm,
                                          logic ill);
        decoded_instr_t d;
        d = '{op: op, fmt: fmt, rd: rd, rs1: rs1, rs2: rs2, imm: imm, illegal: ill};
        return d;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NUM_INSTR; i++) model_cnt[i] = 0;
        model_ill = 0;
    endfunction

    // Encoding table of the supported instruction set (generator side)
    function automatic enc_t enc_of(instructions m);
        case (m)
            ADD:    return '{OPC_R, 3'd0, 7'h00, FMT_R};
            SUB:    return '{OPC_R, 3'd0, 7'h20, FMT_R};
            SLL:    return '{OPC_R, 3'd1, 7'h00, FMT_R};
            SLT:    return '{OPC_R, 3'd2, 7'h00, FMT_R};
            SLTU:   return '{OPC_R, 3'd3, 7'h00, FMT_R};
            XOR:    return '{OPC_R, 3'd4, 7'h00, FMT_R};
            SRL:    return '{OPC_R, 3'd5, 7'h00, FMT_R};
            SRA:    return '{OPC_R, 3'd5, 7'h20, FMT_R};
            OR:     return '{OPC_R, 3'd6, 7'h00, FMT_R};
            AND:    return '{OPC_R, 3'd7, 7'h00, FMT_R};
            MUL:    return '{OPC_R, 3'd0, 7'h01, FMT_R};
            MULH:   return '{OPC_R, 3'd1, 7'h01, FMT_R};
            MULHSU: return '{OPC_R, 3'd2, 7'h01, FMT_R};
            MULHU:  return '{OPC_R, 3'd3, 7'h01, FMT_R};
            DIV:    return '{OPC_R, 3'd4, 7'h01, FMT_R};
            DIVU:   return '{OPC_R, 3'd5, 7'h01, FMT_R};
            REM:    return '{OPC_R, 3'd6, 7'h01, FMT_R};
            REMU:   return '{OPC_R, 3'd7, 7'h01, FMT_R};
            ADDI:   return '{OPC_I, 3'd0, 7'h00, FMT_I};
            SLTI:   return '{OPC_I, 3'd2, 7'h00, FMT_I};
            SLTIU:  return '{OPC_I, 3'd3, 7'h00, FMT_I};
            XORI:   return '{OPC_I, 3'd4, 7'h00, FMT_I};
            ORI:    return '{OPC_I, 3'd6, 7'h00, FMT_I};
            ANDI:   return '{OPC_I, 3'd7, 7'h00, FMT_I};
            SLLI:   return '{OPC_I, 3'd1, 7'h00, FMT_I};
            SRLI:   return '{OPC_I, 3'd5, 7'h00, FMT_I};
            SRAI:   return '{OPC_I, 3'd5, 7'h20, FMT_I};
            LB:     return '{OPC_LOAD, 3'd0, 7'h00, FMT_I};
            LH:     return '{OPC_LOAD, 3'd1, 7'h00, FMT_I};
            LW:     return '{OPC_LOAD, 3'd2, 7'h00, FMT_I};
            LBU:    return '{OPC_LOAD, 3'd4, 7'h00, FMT_I};
            LHU:    return '{OPC_LOAD, 3'd5, 7'h00, FMT_I};
            SB:     return '{OPC_STORE, 3'd0, 7'h00, FMT_S};
            SH:     return '{OPC_STORE, 3'd1, 7'h00, FMT_S};
            SW:     return '{OPC_STORE, 3'd2, 7'h00, FMT_S};
            BEQ:    return '{OPC_BRANCH, 3'd0, 7'h00, FMT_SB};
            BNE:    return '{OPC_BRANCH, 3'd1, 7'h00, FMT_SB};
            BLT:    return '{OPC_BRANCH, 3'd4, 7'h00, FMT_SB};
            BGE:    return '{OPC_BRANCH, 3'd5, 7'h00, FMT_SB};
            BLTU:   return '{OPC_BRANCH, 3'd6, 7'h00, FMT_SB};
            BGEU:   return '{OPC_BRANCH, 3'd7, 7'h00, FMT_SB};
            LUI:    return '{OPC_LUI, 3'd0, 7'h00, FMT_U};
            AUIPC:  return '{OPC_AUIPC, 3'd0, 7'h00, FMT_U};
            JAL:    return '{OPC_JAL, 3'd0, 7'h00, FMT_UJ};
            default: return '{OPC_JALR, 3'd0, 7'h00, FMT_I};
        endcase
    endfunction

    // Build a random legal word from a chosen mnemonic and random field values
    task automatic gen_legal(output logic [31:0] w, output decoded_instr_t e);
        instructions m;
        enc_t        t;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        m   = instructions'($urandom_range(0, NUM_INSTR - 1));
        t   = enc_of(m);
        rd  = 5'($urandom);
        rs1 = 5'($urandom);
        rs2 = 5'($urandom);
        e   = mk(m, t.fmt, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        w   = '0;
        case (t.fmt)
            FMT_R: begin
                w = {t.f7, rs2, rs1, t.f3, rd, t.opc};
                e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
            end
            FMT_I: begin
                if (m inside {SLLI, SRLI, SRAI}) begin
                    imm = 32'($urandom_range(0, 31));
                    w   = {t.f7, imm[4:0], rs1, t.f3, rd, t.opc};
                end else begin
                    imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                    w   = {imm[11:0], rs1, t.f3, rd, t.opc};
                end
                e.rd = rd; e.rs1 = rs1; e.imm = imm;
            end
            FMT_S: begin
                imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                w   = {imm[11:5], rs2, rs1, t.f3, imm[4:0], t.opc};
                e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
            end
            FMT_SB: begin
                imm = (32'($urandom_range(0, 4095)) - 32'd2048) * 2;
                w   = {imm[12], imm[10:5], rs2, rs1, t.f3, imm[4:1], imm[11], t.opc};
                e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
            end
            FMT_U: begin
                imm = $urandom & 32'hFFFF_F000;
                w   = {imm[31:12], rd, t.opc};
                e.rd = rd; e.imm = imm;
            end
            default: begin
                imm = (32'($urandom_range(0, 1048575)) - 32'd524288) * 2;
                w   = {imm[20], imm[10:1], imm[11], imm[19:12], rd, t.opc};
                e.rd = rd; e.imm = imm;
            end
        endcase
    endtask

    // Build a word outside the supported set
    task automatic gen_illegal(output logic [31:0] w, output decoded_instr_t e);
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: w = {r[31:7], 7'b0001111};
            1: w = {r[31:7], 7'b1110011};
            2: w = {7'b0000010, r[24:0]} & 32'hFFFF_FF80 | 32'(OPC_R);
            default: w = {r[31:15], 3'b010, r[11:7], OPC_BRANCH};
        endcase
        e = mk(ADD, FMT_R, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
    endtask

    // One clock: score any output handshake, record any input handshake, advance to edge+1
    task automatic tick(output bit accepted);
        decoded_instr_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("op",      32'(out_op),      32'(e.op));
                chk("fmt",     32'(out_fmt),     32'(e.fmt));
                chk("rd",      32'(out_rd),      32'(e.rd));
                chk("rs1",     32'(out_rs1),     32'(e.rs1));
                chk("rs2",     32'(out_rs2),     32'(e.rs2));
                chk("imm",     out_imm,          e.imm);
                chk("illegal", 32'(out_illegal), 32'(e.illegal));
            end
        end
        if (accepted) exp_q.push_back(pend);
        if (stat_clear) model_clear();
        else if (accepted) begin
            if (pend.illegal) begin
                if (model_ill < SAT_MAX) model_ill++;
            end else if (model_cnt[pend.op] < SAT_MAX) begin
                model_cnt[pend.op]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] w, input decoded_instr_t e);
        in_instr = w; pend = e; in_valid = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        tick(acc);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int k = 0; k < 8 && exp_q.size() != 0; k++) tick(acc);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : main
        decoded_instr_t e_add, e_addi, e_beq, e_jal, e_mul, e_ill, er;
        logic [31:0]    w;

        e_add  = mk(ADD,  FMT_R,  5'd3, 5'd1, 5'd2, 32'h0,        1'b0);
        e_addi = mk(ADDI, FMT_I,  5'd1, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
        e_beq  = mk(BEQ,  FMT_SB, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
        e_jal  = mk(JAL,  FMT_UJ, 5'd1, 5'd0, 5'd0, 32'h0000_0800, 1'b0);
        e_mul  = mk(MUL,  FMT_R,  5'd5, 5'd6, 5'd7, 32'h0,        1'b0);
        e_ill  = mk(ADD,  FMT_R,  5'd0, 5'd0, 5'd0, 32'h0,        1'b1);
        model_clear();

        rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
        stat_sel = 6'(ADD); stat_clear = 1'b0; pend = '0;
        #1;
        chk("rst_in_ready",  32'(in_ready),      32'd1);
        chk("rst_out_valid", 32'(out_valid),     32'd0);
        chk("rst_out_op",    32'(out_op),        32'd0);
        chk("rst_out_imm",   out_imm,            32'd0);
        chk("rst_out_rd",    32'(out_rd),        32'd0);
        chk("rst_stat",      32'(stat_count),    32'd0);
        chk("rst_illcnt",    32'(illegal_count), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed decodes with the consumer always ready
        out_ready = 1'b1;
        send(32'h002081B3, e_add);
        chk("cnt_add_after_add", 32'(stat_count), 32'd1);
        send(32'hFFF00093, e_addi);
        send(32'hFE000EE3, e_beq);
        send(32'h001000EF, e_jal);
        send(32'h027302B3, e_mul);
        send(32'h00000000, e_ill);
        chk("illegal_count_1", 32'(illegal_count), 32'd1);
        chk("cnt_add_unchanged", 32'(stat_count), 32'd1);
        stat_sel = 6'(MUL); #1;
        chk("cnt_mul", 32'(stat_count), 32'd1);

        // Backpressure: three words offered while the consumer stalls
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'hFFF00093; pend = e_addi; tick(acc);
        in_instr = 32'h027302B3; pend = e_mul;  tick(acc);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        in_instr = 32'hFE000EE3; pend = e_beq;  tick(acc);
        chk("bp_third_held", 32'(acc), 32'd0);
        chk("bp_head_op_stable", 32'(out_op), 32'(ADDI));
        chk("bp_head_imm_stable", out_imm, 32'hFFFF_FFFF);
        out_ready = 1'b1;
        tick(acc);
        chk("bp_pop_from_two_no_push", 32'(acc), 32'd0);
        tick(acc);
        chk("bp_push_pop_in_one", 32'(acc), 32'd1);
        in_valid = 1'b0;
        chk("one_stays_one_valid", 32'(out_valid), 32'd1);
        chk("one_stays_one_ready", 32'(in_ready), 32'd1);
        tick(acc);
        chk("bp_empty_after", 32'(out_valid), 32'd0);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset with two entries buffered
        stat_sel = 6'(ADD);
        out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h002081B3; pend = e_add;
        tick(acc);
        tick(acc);
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        chk("pre_rst_cnt_add", 32'(stat_count), 32'(model_cnt[ADD]));
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready",  32'(in_ready),  32'd1);
        chk("midrst_cnt_add",   32'(stat_count), 32'd0);
        chk("midrst_illcnt",    32'(illegal_count), 32'd0);
        exp_q.delete();
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic with random stalls on both sides
        for (int k = 0; k < 600; k++) begin
            if (!in_valid && ($urandom_range(0, 9) < 7)) begin
                if ($urandom_range(0, 9) == 0) gen_illegal(w, er);
                else                           gen_legal(w, er);
                in_instr = w; pend = er; in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) in_valid = 1'b0;
        end
        drain();
        for (int s = 0; s < 48; s++) begin
            stat_sel = 6'(s); #1;
            chk($sformatf("stat_sel_%0d", s), 32'(stat_count),
                (s < NUM_INSTR) ? 32'(model_cnt[s]) : 32'd0);
        end
        chk("rand_illcnt", 32'(illegal_count), 32'(model_ill));

        // Saturation and clear
        stat_sel = 6'(ADD);
        stat_clear = 1'b1; tick(acc); stat_clear = 1'b0;
        chk("clear_add", 32'(stat_count), 32'd0);
        chk("clear_ill", 32'(illegal_count), 32'd0);
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h002081B3; pend = e_add;
        for (int k = 0; k < SAT_MAX + 4; k++) tick(acc);
        in_valid = 1'b0;
        drain();
        chk("sat_add", 32'(stat_count), 32'h0000_FFFF);
        chk("sat_model", 32'(stat_count), 32'(model_cnt[ADD]));
        in_valid = 1'b1; stat_clear = 1'b1;
        tick(acc);
        in_valid = 1'b0; stat_clear = 1'b0;
        chk("clear_beats_incr", 32'(stat_count), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
